// File: rtl/serializer.sv
// serializer: parallel-to-serial converter, MSB-first, one bit per clock.
// Accepts a WIDTH-bit word plus a bit count (0 means WIDTH) and shifts the
// top len bits out on ser_data_o with ser_data_val_o high. busy_o covers
// exactly the cycles that carry valid bits. After each frame there is at
// least one idle cycle, which acts as the frame delimiter.
// Optional feature: define SERIALIZER_LAST_EN to add ser_last_o, which is high
// on the final bit of each frame.
module serializer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MIN_LEN = 3
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] data_mod_i,
  input  logic                     data_val_i,
  output logic                     ser_data_o,
  output logic                     ser_data_val_o,
  output logic                     busy_o
`ifdef SERIALIZER_LAST_EN
  ,
  output logic                     ser_last_o
`endif
);

  localparam int unsigned MW = $clog2(WIDTH);
  localparam int unsigned CW = MW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    len;
  logic             accept;

  // Decode the requested frame length and decide whether the request is taken.
  always_comb begin
    len    = '0;
    accept = 1'b0;
    if (data_mod_i == '0) begin
      len = CW'(WIDTH);
    end else begin
      len = {1'b0, data_mod_i};
    end
    accept = (state_q == IDLE) && data_val_i && (len >= CW'(MIN_LEN));
  end

  // Frame FSM with shift register, remaining-bit counter and registered outputs.
  // The first bit is loaded straight from data_i on accept, so the shift
  // register holds the bits that still have to be sent.
  // cnt_q counts the bits still on the line, including the one shown this cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
`ifdef SERIALIZER_LAST_EN
      ser_last_o     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q        <= SEND;
            ser_data_o     <= data_i[WIDTH-1];
            shift_q        <= {data_i[WIDTH-2:0], 1'b0};
            cnt_q          <= len;
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
`ifdef SERIALIZER_LAST_EN
            ser_last_o     <= (len == CW'(1));
`endif
          end
        end
        SEND: begin
          if (cnt_q == CW'(1)) begin
            state_q        <= IDLE;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
`ifdef SERIALIZER_LAST_EN
            ser_last_o     <= 1'b0;
`endif
          end else begin
            ser_data_o     <= shift_q[WIDTH-1];
            shift_q        <= {shift_q[WIDTH-2:0], 1'b0};
            cnt_q          <= cnt_q - CW'(1);
`ifdef SERIALIZER_LAST_EN
            ser_last_o     <= (cnt_q == CW'(2));
`endif
          end
        end
        default: begin
          state_q        <= IDLE;
          ser_data_o     <= 1'b0;
          ser_data_val_o <= 1'b0;
          busy_o         <= 1'b0;
`ifdef SERIALIZER_LAST_EN
          ser_last_o     <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: randomized and directed frames checked against a
// bit-stream model built from the word and its length.
module tb_serializer;

  localparam int W   = 16;
  localparam int MIN = 3;
`ifdef SERIALIZER_LAST_EN
  localparam bit HAS_LAST = 1'b1;
`else
  localparam bit HAS_LAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic [W-1:0] data = '0;
  logic [3:0]   mod = '0;
  logic         val = 1'b0;
  logic         ser_data, ser_val, busy, ser_last;
  logic [3:0]   obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serializer #(.WIDTH(W), .MIN_LEN(MIN)) dut (
    .clk_i         (clk),
    .arst_i        (arst),
    .data_i        (data),
    .data_mod_i    (mod),
    .data_val_i    (val),
    .ser_data_o    (ser_data),
    .ser_data_val_o(ser_val),
    .busy_o        (busy)
`ifdef SERIALIZER_LAST_EN
    ,
    .ser_last_o    (ser_last)
`endif
  );

`ifndef SERIALIZER_LAST_EN
  assign ser_last = 1'b0;
`endif

  assign obs = {ser_val, busy, ser_data, ser_last};

  // Expected {val,busy,bit,last} while bit number idx (0-based) of a len-bit frame of w is on the line.
  function automatic logic [3:0] exp_bit(input logic [W-1:0] w, input int idx, input int len);
    return {1'b1, 1'b1, w[W-1-idx], HAS_LAST && (idx == len - 1)};
  endfunction

  // Drive one request and check the whole serial stream it should produce.
  task automatic test_frame(input logic [W-1:0] word, input logic [3:0] m, input string name);
    int len;
    logic [W-1:0] rx;
    len = (m == 0) ? W : int'(m);
    @(negedge clk);
    data = word; mod = m; val = 1'b1;
    @(negedge clk);
    val = 1'b0; data = W'($urandom); mod = 4'($urandom);
    if (len < MIN) begin
      for (int c = 0; c < 4; c++) begin
        if (c > 0) @(negedge clk);
        total++;
        if (obs !== 4'b0000) begin
          bad++;
          $display("FAIL %s rejected len=%0d cycle %0d: got %b want 0000", name, len, c, obs);
        end
      end
    end else begin
      rx = '0;
      for (int i = 0; i < len; i++) begin
        if (i > 0) @(negedge clk);
        total++;
        if (obs !== exp_bit(word, i, len)) begin
          bad++;
          $display("FAIL %s bit %0d: got %b want %b", name, i, obs, exp_bit(word, i, len));
        end
        rx = {rx[W-2:0], ser_data};
      end
      total++;
      if (rx !== (word >> (W - len))) begin
        bad++;
        $display("FAIL %s loopback: got %h want %h", name, rx, word >> (W - len));
      end
      @(negedge clk);
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("FAIL %s gap: got %b want 0000", name, obs);
      end
    end
  endtask

  task automatic test_reset();
    #1 arst = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset state: got %b want 0000", obs);
    end
    arst = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL post-reset idle: got %b want 0000", obs);
    end
  endtask

  task automatic test_full_word();
    test_frame(16'hA5C3, 4'd0, "full_word");
  endtask

  task automatic test_short();
    test_frame(16'hE000, 4'd3, "short3");
    test_frame(16'hFFFF, 4'd1, "short1");
    test_frame(16'hFFFF, 4'd2, "short2");
  endtask

  task automatic test_busy_reject();
    logic [W-1:0] word;
    word = 16'hFFFF;
    @(negedge clk);
    data = word; mod = 4'd0; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (obs !== exp_bit(word, i, W)) begin
        bad++;
        $display("FAIL busy_reject bit %0d: got %b want %b", i, obs, exp_bit(word, i, W));
      end
      if (i == 4) begin
        val = 1'b1; data = 16'h0000;
      end else begin
        val = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("FAIL busy_reject no second frame cycle %0d: got %b want 0000", c, obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [3:0] e;
    a = 16'h8001; b = 16'h7FFE;
    @(negedge clk);
    data = a; mod = 4'd0; val = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) data = b;
      if (c == 18) val = 1'b0;
      if (c <= 16) e = exp_bit(a, c - 1, W);
      else if (c == 17 || c == 34) e = 4'b0000;
      else e = exp_bit(b, c - 18, W);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] word;
    word = W'($urandom) | 16'h8000;
    @(negedge clk);
    data = word; mod = 4'd0; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (obs !== exp_bit(word, i, W)) begin
        bad++;
        $display("FAIL reset_mid bit %0d: got %b want %b", i, obs, exp_bit(word, i, W));
      end
    end
    arst = 1'b1;
    #1;
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid abort: got %b want 0000", obs);
    end
    @(negedge clk);
    arst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("FAIL reset_mid quiet cycle %0d: got %b want 0000", c, obs);
      end
    end
    test_frame(16'h1234, 4'd0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      test_frame(W'($urandom), 4'($urandom_range(0, 15)), "random");
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
